// File: rtl/rst_seq_sync_if.sv
// rst_seq_sync_if: control and status bundle for the reset sequencer.
// master drives GAP / SW_RST_REQ and observes the resets; slave is the sequencer.
interface rst_seq_sync_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned GAP_W  = 8
);
  logic [GAP_W-1:0]  GAP;
  logic              SW_RST_REQ;
  logic [NUM_CH-1:0] SYNC_RST;
  logic              RST_DONE;
  logic              SW_RST_ACT;

  modport master (
    output GAP,
    output SW_RST_REQ,
    input  SYNC_RST,
    input  RST_DONE,
    input  SW_RST_ACT
  );

  modport slave (
    input  GAP,
    input  SW_RST_REQ,
    output SYNC_RST,
    output RST_DONE,
    output SW_RST_ACT
  );
endinterface

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: multi-channel reset synchronizer and ordered release sequencer.
// RST asserts every channel asynchronously; deassertion passes through a
// NUM_STAGES flop chain, then channels are released 0..NUM_CH-1 with GAP idle
// cycles between releases.
// Optional feature macro: RST_SEQ_SW_RST_EN builds the synchronous software
// reset (SOFT state, hold counter). Without it SW_RST_REQ is ignored and
// SW_RST_ACT is tied low.
module rst_seq_sync #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned GAP_W      = 8,
  parameter int unsigned HOLD_CYC   = 4
) (
  input  logic         CLK,
  input  logic         RST,
  rst_seq_sync_if.slave bus
);

  localparam int unsigned HOLD_W = 8;

`ifdef RST_SEQ_SW_RST_EN
  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2,
    ST_SOFT    = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;
`endif

  state_e                state_q, state_d;
  logic [NUM_STAGES-1:0] chain_q, chain_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [GAP_W-1:0]      gcnt_q, gcnt_d;
  logic [NUM_CH-1:0]     sync_rst_q, sync_rst_d;
  logic                  rst_done_q, rst_done_d;

  logic                  do_rel;
  logic                  start_rel;
  logic [NUM_CH-1:0]     next_mask;

`ifdef RST_SEQ_SW_RST_EN
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  sw_rst_act_q, sw_rst_act_d;
`else
  logic                  unused_sw_rst_req;
  assign unused_sw_rst_req = bus.SW_RST_REQ;
`endif

  // Channels release strictly in order, so the next release pattern is the
  // current one with one more low-order bit set.
  assign next_mask = NUM_CH'({sync_rst_q, 1'b1});

  // Next-state and output computation.
  always_comb begin
    state_d    = state_q;
    chain_d    = {chain_q[NUM_STAGES-2:0], 1'b1};
    gap_d      = gap_q;
    gcnt_d     = gcnt_q;
    sync_rst_d = sync_rst_q;
    rst_done_d = rst_done_q;
    do_rel     = 1'b0;
    start_rel  = 1'b0;
`ifdef RST_SEQ_SW_RST_EN
    hold_d       = hold_q;
    sw_rst_act_d = sw_rst_act_q;
`endif

    case (state_q)
      ST_SYNC: begin
        if (chain_q[NUM_STAGES-1]) begin
          do_rel    = 1'b1;
          start_rel = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (gcnt_q == '0) begin
          do_rel = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
`ifdef RST_SEQ_SW_RST_EN
      ST_SOFT: begin
        if (hold_q == '0) begin
          do_rel       = 1'b1;
          start_rel    = 1'b1;
          sw_rst_act_d = 1'b0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
`endif
      default: ;
    endcase

    // A release loads the gap counter; a fresh sequence also re-latches GAP.
    if (do_rel) begin
      sync_rst_d = next_mask;
      if (start_rel) begin
        gap_d  = bus.GAP;
        gcnt_d = bus.GAP;
      end else begin
        gcnt_d = gap_q;
      end
      if (&next_mask) begin
        state_d    = ST_DONE;
        rst_done_d = 1'b1;
      end else begin
        state_d    = ST_RELEASE;
      end
    end

`ifdef RST_SEQ_SW_RST_EN
    // A software request overrides any release due on the same edge.
    if (bus.SW_RST_REQ) begin
      state_d      = ST_SOFT;
      sync_rst_d   = '0;
      rst_done_d   = 1'b0;
      sw_rst_act_d = 1'b1;
      hold_d       = HOLD_W'(HOLD_CYC - 1);
    end
`endif
  end

  // State and output registers, cleared asynchronously by RST.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_SYNC;
      chain_q      <= '0;
      gap_q        <= '0;
      gcnt_q       <= '0;
      sync_rst_q   <= '0;
      rst_done_q   <= 1'b0;
`ifdef RST_SEQ_SW_RST_EN
      hold_q       <= '0;
      sw_rst_act_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      chain_q      <= chain_d;
      gap_q        <= gap_d;
      gcnt_q       <= gcnt_d;
      sync_rst_q   <= sync_rst_d;
      rst_done_q   <= rst_done_d;
`ifdef RST_SEQ_SW_RST_EN
      hold_q       <= hold_d;
      sw_rst_act_q <= sw_rst_act_d;
`endif
    end
  end

  assign bus.SYNC_RST   = sync_rst_q;
  assign bus.RST_DONE   = rst_done_q;
`ifdef RST_SEQ_SW_RST_EN
  assign bus.SW_RST_ACT = sw_rst_act_q;
`else
  assign bus.SW_RST_ACT = 1'b0;
`endif

endmodule
